// File: rtl/capture_trig_pkg.sv
// capture_trig_pkg: state encoding, timer width and timer load helper for the capture trigger controller
package capture_trig_pkg;
  localparam int TMR_W = 16;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] PULSE   = 3'd2;
  localparam logic [2:0] HOLDOFF = 3'd3;
  localparam logic [2:0] LOCKED  = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE    = IDLE,
    S_ARMED   = ARMED,
    S_PULSE   = PULSE,
    S_HOLDOFF = HOLDOFF,
    S_LOCKED  = LOCKED
  } state_t;
  function automatic logic [TMR_W-1:0] tmr_load(int n);
    return (n > 0) ? TMR_W'(n - 1) : '0;
  endfunction
endpackage

// File: rtl/capture_trigger_ctrl_if.sv
// capture_trigger_ctrl_if: trigger inputs and capture/status outputs of the capture trigger controller
interface capture_trigger_ctrl_if #(parameter int CNT_WIDTH = 16);
  logic ARM;
  logic TRIG;
  logic CLEAR;
  logic CAP;
  logic BUSY;
  logic DONE;
  logic LOCKED;
  logic [CNT_WIDTH-1:0] CAP_COUNT;
  modport master (input ARM, TRIG, CLEAR, output CAP, BUSY, DONE, LOCKED, CAP_COUNT);
  modport slave (output ARM, TRIG, CLEAR, input CAP, BUSY, DONE, LOCKED, CAP_COUNT);
endinterface

// File: rtl/capture_trig_timer.sv
// capture_trig_timer: loadable down-counter with a registered zero flag, shared by pulse and holdoff
module capture_trig_timer
  import capture_trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d;
  // load wins over decrement; the counter parks at zero
  always_comb begin
    cnt_d  = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    zero_d = (cnt_d == '0);
  end
  // counter and zero flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end
  assign zero = zero_q;
endmodule

// File: rtl/capture_trigger_ctrl.sv
// capture_trigger_ctrl: armed, edge-triggered capture pulse generator; optional TIMESTAMP via CAPTURE_TRIG_TIMESTAMP_EN
module capture_trigger_ctrl
  import capture_trig_pkg::*;
#(
  parameter string ONESHOT     = "TRUE",
  parameter int    PULSE_WIDTH = 1,
  parameter int    HOLDOFF     = 16,
  parameter int    CNT_WIDTH   = 16
) (
  input  logic CLK,
  input  logic RST_N,
  capture_trigger_ctrl_if.master bus
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
  , output logic [31:0] TIMESTAMP
`endif
);
  if (!(ONESHOT == "TRUE" || ONESHOT == "FALSE") || PULSE_WIDTH < 1 || PULSE_WIDTH > 255 ||
      HOLDOFF < 0 || HOLDOFF > 65535) begin : g_bad_cfg
    $fatal(1, "capture_trigger_ctrl: illegal ONESHOT, PULSE_WIDTH or HOLDOFF");
  end
  localparam bit ONE_SHOT = (ONESHOT == "TRUE");
  localparam logic [TMR_W-1:0] PW_LD = tmr_load(PULSE_WIDTH);
  localparam logic [TMR_W-1:0] HO_LD = tmr_load(HOLDOFF);
  state_t state_q, state_d;
  logic trig_q, trig_d1_q, rise;
  logic cap_q, cap_d, busy_q, busy_d, done_q, done_d, locked_q, locked_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic tmr_load_en, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  assign rise = trig_q & ~trig_d1_q;
  capture_trig_timer u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load_en),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );
  // next state, timer control and next output values; CLEAR is dropped while pulsing
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_d      = 1'b0;
    tmr_load_en = 1'b0;
    tmr_en      = 1'b0;
    tmr_val     = PW_LD;
    if (bus.CLEAR && state_q != S_PULSE) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = bus.ARM ? S_ARMED : S_IDLE;
        S_ARMED: begin
          if (!bus.ARM) state_d = S_IDLE;
          else if (rise) begin
            state_d     = S_PULSE;
            tmr_load_en = 1'b1;
          end
        end
        S_PULSE: begin
          if (tmr_zero) begin
            done_d  = 1'b1;
            count_d = &count_q ? count_q : count_q + CNT_WIDTH'(1);
            state_d = ONE_SHOT ? S_LOCKED : (HOLDOFF > 0) ? S_HOLDOFF : bus.ARM ? S_ARMED : S_IDLE;
            tmr_load_en = !ONE_SHOT && HOLDOFF > 0;
            tmr_val     = HO_LD;
          end else tmr_en = 1'b1;
        end
        S_HOLDOFF: begin
          if (tmr_zero) state_d = bus.ARM ? S_ARMED : S_IDLE;
          else tmr_en = 1'b1;
        end
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_IDLE;
      endcase
    end
    cap_d    = (state_d == S_PULSE);
    busy_d   = (state_d == S_PULSE) || (state_d == S_HOLDOFF);
    locked_d = (state_d == S_LOCKED);
  end
  // state, trigger history and output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      trig_q    <= 1'b0;
      trig_d1_q <= 1'b0;
      cap_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      locked_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      trig_q    <= bus.TRIG;
      trig_d1_q <= trig_q;
      cap_q     <= cap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      locked_q  <= locked_d;
      count_q   <= count_d;
    end
  end
  assign bus.CAP       = cap_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.LOCKED    = locked_q;
  assign bus.CAP_COUNT = count_q;
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, stamp_q, stamp_d;
  // stamp holds the post-edge cycle count of the edge where CAP rises
  always_comb begin
    ts_d    = ts_q + 32'd1;
    stamp_d = (state_q == S_ARMED && state_d == S_PULSE) ? ts_d : stamp_q;
  end
  // free-running cycle counter and captured stamp
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ts_q    <= '0;
      stamp_q <= '0;
    end else begin
      ts_q    <= ts_d;
      stamp_q <= stamp_d;
    end
  end
  assign TIMESTAMP = stamp_q;
`endif
endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// tb_capture_trigger_ctrl: directed checks of one-shot, re-arm, ARM priority, CLEAR, reset and count saturation
module tb_capture_trigger_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_c = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int cyc_c = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_c <= rst_c ? cyc_c + 1 : 0;
  capture_trigger_ctrl_if #(.CNT_WIDTH(16)) if_a ();
  capture_trigger_ctrl_if #(.CNT_WIDTH(16)) if_b ();
  capture_trigger_ctrl_if #(.CNT_WIDTH(2))  if_c ();
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
  logic [31:0] ts_a, ts_b, ts_c;
`endif
  capture_trigger_ctrl #(.ONESHOT("TRUE"), .PULSE_WIDTH(1), .HOLDOFF(16), .CNT_WIDTH(16)) u_a (
    .CLK(clk), .RST_N(rst_n), .bus(if_a)
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
    , .TIMESTAMP(ts_a)
`endif
  );
  capture_trigger_ctrl #(.ONESHOT("FALSE"), .PULSE_WIDTH(3), .HOLDOFF(4), .CNT_WIDTH(16)) u_b (
    .CLK(clk), .RST_N(rst_n), .bus(if_b)
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
    , .TIMESTAMP(ts_b)
`endif
  );
  capture_trigger_ctrl #(.ONESHOT("FALSE"), .PULSE_WIDTH(4), .HOLDOFF(0), .CNT_WIDTH(2)) u_c (
    .CLK(clk), .RST_N(rst_c), .bus(if_c)
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
    , .TIMESTAMP(ts_c)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    {if_a.ARM, if_a.TRIG, if_a.CLEAR} = '0;
    {if_b.ARM, if_b.TRIG, if_b.CLEAR} = '0;
    {if_c.ARM, if_c.TRIG, if_c.CLEAR} = '0;
    step(2);
    chk("rst_cap", if_a.CAP, 0);
    chk("rst_busy", if_a.BUSY, 0);
    chk("rst_done", if_a.DONE, 0);
    chk("rst_locked", if_a.LOCKED, 0);
    chk("rst_count", if_a.CAP_COUNT, 0);
    rst_n = 1'b1;
    rst_c = 1'b1;
    // one-shot, width 1; CLEAR during the pulse is dropped
    if_a.ARM = 1'b1;
    step(1);
    if_a.TRIG = 1'b1;
    step(1);
    chk("a_cap_latency", if_a.CAP, 0);
    step(1);
    chk("a_cap_rise", if_a.CAP, 1);
    chk("a_busy_pulse", if_a.BUSY, 1);
    chk("a_done_early", if_a.DONE, 0);
    if_a.CLEAR = 1'b1;
    step(1);
    if_a.CLEAR = 1'b0;
    chk("a_cap_fall", if_a.CAP, 0);
    chk("a_done", if_a.DONE, 1);
    chk("a_count", if_a.CAP_COUNT, 1);
    chk("a_locked", if_a.LOCKED, 1);
    chk("a_busy_end", if_a.BUSY, 0);
    step(1);
    chk("a_done_once", if_a.DONE, 0);
    if_a.TRIG = 1'b0;
    step(1);
    if_a.TRIG = 1'b1;
    step(3);
    chk("a_locked_nocap", if_a.CAP, 0);
    chk("a_locked_hold", if_a.LOCKED, 1);
    chk("a_count_hold", if_a.CAP_COUNT, 1);
    if_a.CLEAR = 1'b1;
    step(1);
    if_a.CLEAR = 1'b0;
    chk("a_clr_unlock", if_a.LOCKED, 0);
    chk("a_clr_count", if_a.CAP_COUNT, 0);
    if_a.ARM = 1'b0;
    if_a.TRIG = 1'b0;
    // auto re-arm, width 3, holdoff 4
    if_b.TRIG = 1'b1;
    step(3);
    if_b.ARM = 1'b1;
    step(4);
    chk("b_held_nocap", if_b.CAP, 0);
    chk("b_held_idle", if_b.BUSY, 0);
    if_b.TRIG = 1'b0;
    step(1);
    if_b.TRIG = 1'b1;
    step(1);
    chk("b_cap_latency", if_b.CAP, 0);
    step(1);
    chk("b_cap_rise", if_b.CAP, 1);
    step(2);
    chk("b_cap_third", if_b.CAP, 1);
    step(1);
    chk("b_cap_fall", if_b.CAP, 0);
    chk("b_done", if_b.DONE, 1);
    chk("b_busy_holdoff", if_b.BUSY, 1);
    chk("b_count1", if_b.CAP_COUNT, 1);
    if_b.TRIG = 1'b0;
    step(1);
    if_b.TRIG = 1'b1;
    step(2);
    chk("b_ho_ignore_cap", if_b.CAP, 0);
    chk("b_ho_busy", if_b.BUSY, 1);
    step(1);
    chk("b_rearm_busy", if_b.BUSY, 0);
    chk("b_rearm_cap", if_b.CAP, 0);
    if_b.TRIG = 1'b0;
    step(1);
    if_b.TRIG = 1'b1;
    step(2);
    chk("b_cap_rise2", if_b.CAP, 1);
    step(3);
    chk("b_cap_fall2", if_b.CAP, 0);
    chk("b_count2", if_b.CAP_COUNT, 2);
    step(5);
    if_b.TRIG = 1'b0;
    step(1);
    if_b.TRIG = 1'b1;
    step(1);
    if_b.ARM = 1'b0;
    step(2);
    chk("b_armwin_cap", if_b.CAP, 0);
    chk("b_armwin_busy", if_b.BUSY, 0);
    if_b.ARM = 1'b1;
    step(3);
    chk("b_armwin_noqueue", if_b.CAP, 0);
    chk("b_armwin_count", if_b.CAP_COUNT, 2);
    if_b.ARM = 1'b0;
    // reset mid-pulse, then count saturation at width 2
    if_c.ARM = 1'b1;
    step(1);
    if_c.TRIG = 1'b1;
    step(2);
    chk("c_cap_rise", if_c.CAP, 1);
    step(1);
    rst_c = 1'b0;
    step(1);
    chk("c_rst_cap", if_c.CAP, 0);
    chk("c_rst_busy", if_c.BUSY, 0);
    chk("c_rst_done", if_c.DONE, 0);
    chk("c_rst_count", if_c.CAP_COUNT, 0);
    rst_c = 1'b1;
    if_c.TRIG = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      if_c.TRIG = 1'b0;
      step(1);
      if_c.TRIG = 1'b1;
      step(2);
      chk($sformatf("c_rise%0d", i), if_c.CAP, 1);
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
      chk($sformatf("c_ts%0d", i), ts_c, cyc_c);
`endif
      step(4);
      chk($sformatf("c_done%0d", i), if_c.DONE, 1);
      chk($sformatf("c_count%0d", i), if_c.CAP_COUNT, (i + 1 > 3) ? 3 : i + 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
